// File: rtl/jtcps1_arb_pkg.sv
// Shared types and constants for the CPS SDRAM bank arbiter.
// JTCPS1_ARB_RR_EN selects the rotating ba1..ba3 priority variant.
package jtcps1_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_st_e;

   localparam logic [1:0] BA0 = 2'd0;
   localparam logic [1:0] BA1 = 2'd1;
   localparam logic [1:0] BA2 = 2'd2;
   localparam logic [1:0] BA3 = 2'd3;

   // Fixed priority, element 0 is the highest
   localparam logic [3:0][1:0] PRIO_ORDER = {BA1, BA2, BA3, BA0};

   // Next bank in the ba1->ba2->ba3->ba1 rotation (0 maps to ba1)
   function automatic logic [1:0] rr_next(input logic [1:0] b);
      return (b == BA3) ? BA1 : b + 2'd1;
   endfunction

endpackage

// File: rtl/jtcps1_arb_pick.sv
// Combinational winner select for the SDRAM bank arbiter.
// JTCPS1_ARB_RR_EN adds a rotation pointer port for ba1..ba3.
module jtcps1_arb_pick
   import jtcps1_arb_pkg::*;
(
   input  logic [3:0] req_i,
   input  logic       starve_i,
`ifdef JTCPS1_ARB_RR_EN
   input  logic [1:0] rr_ptr_i,
`endif
   output logic [1:0] ba_o,
   output logic       vld_o
);

`ifdef JTCPS1_ARB_RR_EN
   logic [1:0] c1, c2, c3;
   assign c1 = rr_next(rr_ptr_i);
   assign c2 = rr_next(c1);
   assign c3 = rr_next(c2);
`endif

   always_comb begin
      ba_o  = BA0;
      vld_o = |req_i;
`ifdef JTCPS1_ARB_RR_EN
      // Lowest rank first so higher ranks overwrite
      if (req_i[c3])  ba_o = c3;
      if (req_i[c2])  ba_o = c2;
      if (req_i[c1])  ba_o = c1;
      if (req_i[BA0]) ba_o = BA0;
`else
      for (int i = 3; i >= 0; i--)
         if (req_i[PRIO_ORDER[i]]) ba_o = PRIO_ORDER[i];
`endif
      if (starve_i && req_i[BA2]) ba_o = BA2;
   end

endmodule

// File: rtl/jtcps1_sdram_arb.sv
// Four-bank SDRAM request arbiter with refresh insertion, one transaction in flight.
// Define JTCPS1_ARB_RR_EN for rotating priority among ba1..ba3.
module jtcps1_sdram_arb
   import jtcps1_arb_pkg::*;
#(
   parameter int AW       = 22,
   parameter int MAX_WAIT = 64,
   parameter int RFSH_CNT = 192
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          refresh_en,
   input  logic [AW-1:0] ba0_addr,
   input  logic          ba0_rd,
   input  logic          ba0_wr,
   input  logic [15:0]   ba0_din,
   input  logic [1:0]    ba0_din_m,
   input  logic [AW-1:0] ba1_addr,
   input  logic          ba1_rd,
   input  logic [AW-1:0] ba2_addr,
   input  logic          ba2_rd,
   input  logic [AW-1:0] ba3_addr,
   input  logic          ba3_rd,
   output logic          ba0_ack,
   output logic          ba1_ack,
   output logic          ba2_ack,
   output logic          ba3_ack,
   output logic          ba0_rdy,
   output logic          ba1_rdy,
   output logic          ba2_rdy,
   output logic          ba3_rdy,
   output logic          sd_req,
   output logic [1:0]    sd_ba,
   output logic [AW-1:0] sd_addr,
   output logic          sd_wr,
   output logic [15:0]   sd_din,
   output logic [1:0]    sd_din_m,
   output logic          sd_rfsh,
   input  logic          sd_gnt,
   input  logic          sd_dok
);

   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam int RW = $clog2(RFSH_CNT + 1);
   localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
   localparam logic [RW-1:0] RFSH_LD  = RW'(RFSH_CNT);

   arb_st_e       state_q;
   logic [1:0]    owner_q;
   logic          rfsh_own_q;
   logic          sd_req_q, sd_rfsh_q, sd_wr_q;
   logic [1:0]    sd_ba_q, sd_din_m_q;
   logic [AW-1:0] sd_addr_q;
   logic [15:0]   sd_din_q;
   logic [3:0]    ack_q, rdy_q;
   logic [WW-1:0] wait_q, wait_d;
   logic [RW-1:0] rc_q, rc_d;
   logic          pend_q, pend_d;

   logic [3:0]    req;
   logic [1:0]    pick_ba;
   logic          pick_vld, starve, gnt_ev, ba2_own;
   logic [AW-1:0] pick_addr;

   assign req     = {ba3_rd, ba2_rd, ba1_rd, ba0_rd | ba0_wr};
   assign starve  = (wait_q == WAIT_MAX);
   assign gnt_ev  = (state_q == ISSUE) && sd_gnt;
   assign ba2_own = (state_q != IDLE) && !rfsh_own_q && (owner_q == BA2);

`ifdef JTCPS1_ARB_RR_EN
   logic [1:0] rr_q, rr_d;

   always_comb begin
      rr_d = rr_q;
      if (gnt_ev && !rfsh_own_q && owner_q != BA0) rr_d = owner_q;
   end

   always_ff @(posedge clk) begin
      if (rst) rr_q <= BA0;
      else     rr_q <= rr_d;
   end
`endif

   jtcps1_arb_pick u_pick (
      .req_i    (req),
      .starve_i (starve),
`ifdef JTCPS1_ARB_RR_EN
      .rr_ptr_i (rr_q),
`endif
      .ba_o     (pick_ba),
      .vld_o    (pick_vld)
   );

   always_comb begin
      case (pick_ba)
         BA1:     pick_addr = ba1_addr;
         BA2:     pick_addr = ba2_addr;
         BA3:     pick_addr = ba3_addr;
         default: pick_addr = ba0_addr;
      endcase
   end

   always_comb begin
      wait_d = wait_q;
      if (gnt_ev && !rfsh_own_q && owner_q == BA2)  wait_d = '0;
      else if (ba2_rd && !ba2_own && !starve)       wait_d = wait_q + WW'(1);

      rc_d   = rc_q;
      pend_d = pend_q;
      if (gnt_ev && rfsh_own_q) pend_d = 1'b0;
      // A reload in the same cycle as a refresh grant re-arms pending
      if (refresh_en) begin
         if (rc_q == '0) begin
            rc_d   = RFSH_LD;
            pend_d = 1'b1;
         end else begin
            rc_d = rc_q - RW'(1);
         end
      end else begin
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_q <= '0;
         rc_q   <= RFSH_LD;
         pend_q <= 1'b0;
      end else begin
         wait_q <= wait_d;
         rc_q   <= rc_d;
         pend_q <= pend_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= BA0;
         rfsh_own_q <= 1'b0;
         sd_req_q   <= 1'b0;
         sd_rfsh_q  <= 1'b0;
         sd_wr_q    <= 1'b0;
         sd_ba_q    <= '0;
         sd_addr_q  <= '0;
         sd_din_q   <= '0;
         sd_din_m_q <= '0;
         ack_q      <= '0;
         rdy_q      <= '0;
      end else begin
         ack_q <= '0;
         rdy_q <= '0;
         case (state_q)
            IDLE: begin
               if (pend_q && refresh_en) begin
                  sd_rfsh_q  <= 1'b1;
                  rfsh_own_q <= 1'b1;
                  state_q    <= ISSUE;
               end else if (pick_vld) begin
                  sd_req_q   <= 1'b1;
                  rfsh_own_q <= 1'b0;
                  owner_q    <= pick_ba;
                  sd_ba_q    <= pick_ba;
                  sd_addr_q  <= pick_addr;
                  sd_wr_q    <= (pick_ba == BA0) && ba0_wr;
                  sd_din_q   <= ba0_din;
                  sd_din_m_q <= ba0_din_m;
                  state_q    <= ISSUE;
               end
            end
            ISSUE: begin
               if (sd_gnt) begin
                  sd_req_q  <= 1'b0;
                  sd_rfsh_q <= 1'b0;
                  if (rfsh_own_q) begin
                     state_q <= IDLE;
                  end else begin
                     ack_q[owner_q] <= 1'b1;
                     state_q        <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (sd_dok) begin
                  rdy_q[owner_q] <= 1'b1;
                  state_q        <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign {ba3_ack, ba2_ack, ba1_ack, ba0_ack} = ack_q;
   assign {ba3_rdy, ba2_rdy, ba1_rdy, ba0_rdy} = rdy_q;
   assign sd_req   = sd_req_q;
   assign sd_rfsh  = sd_rfsh_q;
   assign sd_ba    = sd_ba_q;
   assign sd_addr  = sd_addr_q;
   assign sd_wr    = sd_wr_q;
   assign sd_din   = sd_din_q;
   assign sd_din_m = sd_din_m_q;

endmodule

// File: tb/tb_jtcps1_sdram_arb.sv
// Scoreboard bench for jtcps1_sdram_arb; a controller model answers commands,
// a monitor pops expected command/ack/rdy/refresh events as they appear.
module tb_jtcps1_sdram_arb;

   localparam int AW = 22, MAX_WAIT = 64, RFSH_CNT = 192, TXN = 12;
   localparam int K_CMD = 0, K_ACK = 1, K_RDY = 2, K_RFSH = 3;

   logic clk = 1'b0, rst = 1'b1, refresh_en = 1'b0;
   logic [AW-1:0] ba0_addr = '0, ba1_addr = '0, ba2_addr = '0, ba3_addr = '0;
   logic ba0_rd = 0, ba0_wr = 0, ba1_rd = 0, ba2_rd = 0, ba3_rd = 0;
   logic [15:0] ba0_din = '0;
   logic [1:0]  ba0_din_m = '0;
   logic ba0_ack, ba1_ack, ba2_ack, ba3_ack, ba0_rdy, ba1_rdy, ba2_rdy, ba3_rdy;
   logic sd_req, sd_wr, sd_rfsh;
   logic [1:0] sd_ba, sd_din_m;
   logic [AW-1:0] sd_addr;
   logic [15:0] sd_din;
   logic sd_gnt = 0, sd_dok = 0;

   always #5 clk = ~clk;

   jtcps1_sdram_arb #(.AW(AW), .MAX_WAIT(MAX_WAIT), .RFSH_CNT(RFSH_CNT)) dut (
      .clk(clk), .rst(rst), .refresh_en(refresh_en),
      .ba0_addr(ba0_addr), .ba0_rd(ba0_rd), .ba0_wr(ba0_wr), .ba0_din(ba0_din), .ba0_din_m(ba0_din_m),
      .ba1_addr(ba1_addr), .ba1_rd(ba1_rd), .ba2_addr(ba2_addr), .ba2_rd(ba2_rd),
      .ba3_addr(ba3_addr), .ba3_rd(ba3_rd),
      .ba0_ack(ba0_ack), .ba1_ack(ba1_ack), .ba2_ack(ba2_ack), .ba3_ack(ba3_ack),
      .ba0_rdy(ba0_rdy), .ba1_rdy(ba1_rdy), .ba2_rdy(ba2_rdy), .ba3_rdy(ba3_rdy),
      .sd_req(sd_req), .sd_ba(sd_ba), .sd_addr(sd_addr), .sd_wr(sd_wr),
      .sd_din(sd_din), .sd_din_m(sd_din_m), .sd_rfsh(sd_rfsh),
      .sd_gnt(sd_gnt), .sd_dok(sd_dok)
   );

   wire [3:0] ack = {ba3_ack, ba2_ack, ba1_ack, ba0_ack};
   wire [3:0] rdy = {ba3_rdy, ba2_rdy, ba1_rdy, ba0_rdy};
   wire [AW+26:0] all_out = {sd_req, sd_rfsh, sd_ba, sd_addr, sd_wr, sd_din, sd_din_m, ack, rdy};

   typedef struct {
      int kind; int ba; logic [AW-1:0] addr; logic wr; logic [15:0] din; logic [1:0] m;
   } exp_t;
   exp_t q[$];

   int  checks = 0, fails = 0;
   bit  auto_ctl = 1;
   int  ack2_cyc, rfsh_gnts;

   task automatic push(input int kind, input int ba, input logic [AW-1:0] addr = '0,
                       input logic wr = 0, input logic [15:0] din = '0, input logic [1:0] m = '0);
      exp_t e;
      e.kind = kind; e.ba = ba; e.addr = addr; e.wr = wr; e.din = din; e.m = m;
      q.push_back(e);
   endtask

   task automatic push_txn(input int ba, input logic [AW-1:0] addr, input logic wr = 0,
                           input logic [15:0] din = '0, input logic [1:0] m = '0);
      push(K_CMD, ba, addr, wr, din, m);
      push(K_ACK, ba);
      push(K_RDY, ba);
   endtask

   task automatic check_ev(input int kind, input int ba);
      exp_t e;
      checks++;
      if (q.size() == 0) begin
         fails++;
         $display("FAIL ev_unexpected got kind=%0d ba=%0d required no event", kind, ba);
      end else begin
         e = q.pop_front();
         if (e.kind != kind || e.ba != ba ||
             (kind == K_CMD && (e.addr != sd_addr || e.wr != sd_wr ||
                                (e.wr && (e.din != sd_din || e.m != sd_din_m))))) begin
            fails++;
            $display("FAIL ev_order got kind=%0d ba=%0d addr=%h wr=%0d din=%h m=%b required kind=%0d ba=%0d addr=%h wr=%0d din=%h m=%b",
                     kind, ba, sd_addr, sd_wr, sd_din, sd_din_m, e.kind, e.ba, e.addr, e.wr, e.din, e.m);
         end
      end
   endtask

   task automatic monitor();
      logic prev_req = 0, prev_rfsh = 0;
      forever begin
         @(negedge clk);
         if (sd_req && !prev_req)   check_ev(K_CMD, int'(sd_ba));
         if (sd_rfsh && !prev_rfsh) check_ev(K_RFSH, 0);
         for (int b = 0; b < 4; b++) if (ack[b]) check_ev(K_ACK, b);
         for (int b = 0; b < 4; b++) if (rdy[b]) check_ev(K_RDY, b);
         prev_req  = sd_req;
         prev_rfsh = sd_rfsh;
      end
   endtask

   // Controller model: gnt 3 cycles after the command appears, dok 5 cycles after gnt
   task automatic responder();
      bit is_r;
      forever begin
         @(negedge clk);
         if (auto_ctl && (sd_req || sd_rfsh)) begin
            is_r = sd_rfsh;
            repeat (3) @(negedge clk);
            sd_gnt = 1;
            @(negedge clk);
            sd_gnt = 0;
            if (!is_r) begin
               repeat (4) @(negedge clk);
               sd_dok = 1;
               @(negedge clk);
               sd_dok = 0;
            end
         end
      end
   endtask

   task automatic drop(input int b);
      case (b)
         0: begin ba0_rd = 0; ba0_wr = 0; end
         1: ba1_rd = 0;
         2: ba2_rd = 0;
         default: ba3_rd = 0;
      endcase
   endtask

   task automatic drain(input string name, input int budget, input logic [3:0] drop_en,
                        input int stop_after, input bit kill2, output int a2c);
      int nack = 0, quiet = 0;
      a2c = -1;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         for (int b = 0; b < 4; b++) begin
            if (ack[b]) begin
               nack++;
               if (drop_en[b]) drop(b);
               if (b == 2 && a2c < 0) a2c = c;
               if (b == 2 && kill2) begin ba2_rd = 0; ba3_rd = 0; end
            end
         end
         if (stop_after > 0 && nack == stop_after) begin ba1_rd = 0; ba2_rd = 0; ba3_rd = 0; end
         if (q.size() == 0 && !sd_req && !sd_rfsh) quiet++;
         else quiet = 0;
         if (quiet >= 3) break;
      end
      checks++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL %s_drain got %0d events outstanding required 0", name, q.size());
      end
      q.delete();
   endtask

   initial begin
      fork
         monitor();
         responder();
      join_none

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (all_out != '0) begin fails++; $display("FAIL reset_outs got %h required 0", all_out); end
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      checks++;
      if (all_out != '0) begin fails++; $display("FAIL post_reset_outs got %h required 0", all_out); end

      // Single ba1 read
      @(posedge clk); #1 ba1_addr = 22'h012345; ba1_rd = 1;
      push_txn(1, 22'h012345);
      @(posedge clk); #1 ba1_rd = 0;
      drain("single_ba1", 200, 4'b0000, 0, 0, ack2_cyc);

      // ba0 write (with rd also set) + ba3 + ba2 together
      @(posedge clk); #1;
      ba0_addr = 22'h00ABCD; ba0_wr = 1; ba0_rd = 1; ba0_din = 16'hA5C3; ba0_din_m = 2'b10;
      ba3_addr = 22'h3C0003; ba3_rd = 1;
      ba2_addr = 22'h2B0002; ba2_rd = 1;
      push_txn(0, 22'h00ABCD, 1, 16'hA5C3, 2'b10);
`ifdef JTCPS1_ARB_RR_EN
      push_txn(2, 22'h2B0002);
      push_txn(3, 22'h3C0003);
`else
      push_txn(3, 22'h3C0003);
      push_txn(2, 22'h2B0002);
`endif
      drain("three_way", 300, 4'b1101, 0, 0, ack2_cyc);

      // ba3 held, ba2 held: starvation forces ba2 through
      @(posedge clk); #1;
      ba3_addr = 22'h3F1234; ba3_rd = 1;
      ba2_addr = 22'h2E5678; ba2_rd = 1;
`ifndef JTCPS1_ARB_RR_EN
      repeat (7) push_txn(3, 22'h3F1234);
`endif
      push_txn(2, 22'h2E5678);
      drain("starve", 400, 4'b0000, 0, 1, ack2_cyc);
      checks++;
      if (ack2_cyc < 0 || ack2_cyc > MAX_WAIT + 2 * TXN) begin
         fails++;
         $display("FAIL starve_latency got %0d cycles required <= %0d", ack2_cyc, MAX_WAIT + 2 * TXN);
      end

      // Reset while waiting for data
      auto_ctl = 0;
      @(posedge clk); #1 ba1_addr = 22'h111111; ba1_rd = 1;
      push(K_CMD, 1, 22'h111111);
      push(K_ACK, 1);
      @(posedge clk); #1 ba1_rd = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (sd_req) break;
      end
      sd_gnt = 1;
      @(negedge clk);
      sd_gnt = 0;
      rst = 1;
      @(negedge clk);
      checks++;
      if (all_out != '0) begin fails++; $display("FAIL rst_in_wait got %h required 0", all_out); end
      rst = 0;
      @(negedge clk);
      sd_dok = 1;
      @(negedge clk);
      sd_dok = 0;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (rdy != 4'b0) begin fails++; $display("FAIL late_dok_rdy got %b required 0000", rdy); end
         @(negedge clk);
      end
      drain("rst_wait", 20, 4'b0000, 0, 0, ack2_cyc);
      auto_ctl = 1;

      // Refresh only, 400 cycles
      @(posedge clk); #1 refresh_en = 1;
      push(K_RFSH, 0);
      push(K_RFSH, 0);
      rfsh_gnts = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (sd_rfsh && sd_gnt) rfsh_gnts++;
      end
      refresh_en = 0;
      checks++;
      if (rfsh_gnts != 2) begin fails++; $display("FAIL rfsh_count got %0d required 2", rfsh_gnts); end
      drain("refresh", 50, 4'b0000, 0, 0, ack2_cyc);

      // ba1..ba3 all requesting
      @(posedge clk); #1;
      ba1_addr = 22'h100001; ba2_addr = 22'h200002; ba3_addr = 22'h300003;
      ba1_rd = 1; ba2_rd = 1; ba3_rd = 1;
`ifdef JTCPS1_ARB_RR_EN
      repeat (2) begin
         push_txn(1, 22'h100001);
         push_txn(2, 22'h200002);
         push_txn(3, 22'h300003);
      end
      drain("rotate", 300, 4'b0000, 6, 0, ack2_cyc);
`else
      push_txn(3, 22'h300003);
      push_txn(2, 22'h200002);
      push_txn(1, 22'h100001);
      drain("fixed_order", 300, 4'b1110, 0, 0, ack2_cyc);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
